load_store_unit: RTL and testbench

//  Memory stage of the RV32I core, directly downstream of the ALU: takes the ALU result as the effective address.

---
 rtl/load_store_unit_if.sv | 35 +++
 rtl/load_store_unit.sv | 209 ++++++++++++++++++++
 tb/tb_load_store_unit.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/load_store_unit_if.sv
// -----------------------------------------------------------------------------
// load_store_unit_if
// Data-memory bus between the load/store unit (master) and the data memory
// (slave). Request phase: DmemReq_o held with address/controls until
// DmemGnt_i. Response phase (reads only): DmemRvalid_i with DmemRdata_i,
// never in the same cycle as the grant.
//   DmemReq_o    master->slave  bus request
//   DmemWe_o     master->slave  1=write, 0=read
//   DmemAddr_o   master->slave  word-aligned address
//   DmemBe_o     master->slave  byte enables
//   DmemWdata_o  master->slave  lane-replicated write data
//   DmemGnt_i    slave->master  request accepted this cycle
//   DmemRvalid_i slave->master  read data valid this cycle
//   DmemRdata_i  slave->master  read data word
// -----------------------------------------------------------------------------
interface load_store_unit_if;
    logic        DmemReq_o;
    logic        DmemWe_o;
    logic [31:0] DmemAddr_o;
    logic [3:0]  DmemBe_o;
    logic [31:0] DmemWdata_o;
    logic        DmemGnt_i;
    logic        DmemRvalid_i;
    logic [31:0] DmemRdata_i;

    modport master (
        output DmemReq_o, DmemWe_o, DmemAddr_o, DmemBe_o, DmemWdata_o,
        input  DmemGnt_i, DmemRvalid_i, DmemRdata_i
    );

    modport slave (
        input  DmemReq_o, DmemWe_o, DmemAddr_o, DmemBe_o, DmemWdata_o,
        output DmemGnt_i, DmemRvalid_i, DmemRdata_i
    );
endinterface

// File: rtl/load_store_unit.sv
// -----------------------------------------------------------------------------
// load_store_unit
// Memory stage of the RV32I core. Takes one load or store from EX, runs it
// over the data-memory bus, aligns store data / byte enables, extends load
// data for write-back and reports misaligned, illegal and timeout faults.
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   Valid_i              EX presents a memory op
//   MemRead_i/MemWrite_i op kind
//   Funct3_i             size/sign (B,H,W,BU,HU)
//   Addr_i, StoreData_i  effective address, rs2 value
//   Ready_o              unit idle (combinational from state)
//   dmem                 data-memory bus (master side)
//   LoadValid_o/LoadData_o  load result pulse / held data
//   StoreDone_o          store granted pulse
//   Fault_o/FaultCause_o abort pulse / held cause (01 mis, 10 ill, 11 t/o)
// -----------------------------------------------------------------------------
module load_store_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      Valid_i,
    input  logic                      MemRead_i,
    input  logic                      MemWrite_i,
    input  logic [2:0]                Funct3_i,
    input  logic [31:0]               Addr_i,
    input  logic [31:0]               StoreData_i,
    output logic                      Ready_o,
    load_store_unit_if.master         dmem,
    output logic                      LoadValid_o,
    output logic [31:0]               LoadData_o,
    output logic                      StoreDone_o,
    output logic                      Fault_o,
    output logic [1:0]                FaultCause_o
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        REQ  = 2'b01,
        WAIT = 2'b10
    } state_t;

    localparam logic [31:0] TO_LAST = 32'(TIMEOUT_CYCLES) - 32'd1;

    // Byte enables for a store; f3[1:0] carries the access size.
    function automatic logic [3:0] store_be(input logic [2:0] f3, input logic [1:0] off);
        case (f3[1:0])
            2'b00:   store_be = 4'b0001 << off;
            2'b01:   store_be = 4'b0011 << {off[1], 1'b0};
            default: store_be = 4'b1111;
        endcase
    endfunction

    // Store data replicated across every lane it could land in.
    function automatic logic [31:0] store_wdata(input logic [2:0] f3, input logic [31:0] d);
        case (f3[1:0])
            2'b00:   store_wdata = {4{d[7:0]}};
            2'b01:   store_wdata = {2{d[15:0]}};
            default: store_wdata = d;
        endcase
    endfunction

    // Shift the addressed bytes to bit 0, then sign/zero extend.
    function automatic logic [31:0] load_extend(input logic [31:0] rdata, input logic [2:0] f3,
                                                input logic [1:0] off);
        logic [31:0] word;
        word = rdata >> {off, 3'b000};
        case (f3)
            3'b000:  load_extend = {{24{word[7]}}, word[7:0]};
            3'b001:  load_extend = {{16{word[15]}}, word[15:0]};
            3'b100:  load_extend = {24'd0, word[7:0]};
            3'b101:  load_extend = {16'd0, word[15:0]};
            default: load_extend = word;
        endcase
    endfunction

    state_t      state_r;
    logic        req_r, we_r, is_load_r;
    logic [31:0] addr_r, wdata_r, load_data_r, cnt_r;
    logic [3:0]  be_r;
    logic [2:0]  funct3_r;
    logic [1:0]  offset_r, cause_r;
    logic        load_valid_r, store_done_r, fault_r;

    logic        accept_s, illegal_s, misaligned_s, timeout_s;

    // Accept decode, legality (checked before alignment) and timeout detect.
    always_comb begin
        accept_s     = Valid_i & (state_r == IDLE) & (MemRead_i | MemWrite_i);
        illegal_s    = 1'b0;
        misaligned_s = 1'b0;
        timeout_s    = 1'b0;
        if (MemRead_i & MemWrite_i) begin
            illegal_s = 1'b1;
        end else if (MemRead_i) begin
            illegal_s = (Funct3_i == 3'b011) | (Funct3_i == 3'b110) | (Funct3_i == 3'b111);
        end else begin
            illegal_s = MemWrite_i & (Funct3_i != 3'b000) & (Funct3_i != 3'b001)
                        & (Funct3_i != 3'b010);
        end
        if (Funct3_i[1:0] == 2'b01) begin
            misaligned_s = Addr_i[0];
        end else if (Funct3_i[1:0] == 2'b10) begin
            misaligned_s = (Addr_i[1:0] != 2'b00);
        end else begin
            misaligned_s = 1'b0;
        end
        if (TIMEOUT_CYCLES != 0) begin
            timeout_s = (cnt_r == TO_LAST);
        end else begin
            timeout_s = 1'b0;
        end
    end

    // Transaction FSM with registered bus controls and result pulses.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r      <= IDLE;
            req_r        <= 1'b0;
            we_r         <= 1'b0;
            is_load_r    <= 1'b0;
            addr_r       <= 32'd0;
            wdata_r      <= 32'd0;
            be_r         <= 4'd0;
            funct3_r     <= 3'd0;
            offset_r     <= 2'd0;
            cnt_r        <= 32'd0;
            load_data_r  <= 32'd0;
            load_valid_r <= 1'b0;
            store_done_r <= 1'b0;
            fault_r      <= 1'b0;
            cause_r      <= 2'd0;
        end else begin
            load_valid_r <= 1'b0;
            store_done_r <= 1'b0;
            fault_r      <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        cnt_r <= 32'd0;
                        if (illegal_s) begin
                            fault_r <= 1'b1;
                            cause_r <= 2'b10;
                        end else if (misaligned_s) begin
                            fault_r <= 1'b1;
                            cause_r <= 2'b01;
                        end else begin
                            state_r   <= REQ;
                            req_r     <= 1'b1;
                            we_r      <= MemWrite_i;
                            is_load_r <= MemRead_i;
                            addr_r    <= {Addr_i[31:2], 2'b00};
                            be_r      <= MemRead_i ? 4'b1111 : store_be(Funct3_i, Addr_i[1:0]);
                            wdata_r   <= MemRead_i ? 32'd0 : store_wdata(Funct3_i, StoreData_i);
                            funct3_r  <= Funct3_i;
                            offset_r  <= Addr_i[1:0];
                        end
                    end
                end
                REQ: begin
                    cnt_r <= cnt_r + 32'd1;
                    if (dmem.DmemGnt_i) begin
                        req_r <= 1'b0;
                        if (is_load_r) begin
                            state_r <= WAIT;
                        end else begin
                            state_r      <= IDLE;
                            store_done_r <= 1'b1;
                        end
                    end else if (timeout_s) begin
                        state_r <= IDLE;
                        req_r   <= 1'b0;
                        fault_r <= 1'b1;
                        cause_r <= 2'b11;
                    end
                end
                WAIT: begin
                    cnt_r <= cnt_r + 32'd1;
                    if (dmem.DmemRvalid_i) begin
                        state_r      <= IDLE;
                        load_valid_r <= 1'b1;
                        load_data_r  <= load_extend(dmem.DmemRdata_i, funct3_r, offset_r);
                    end else if (timeout_s) begin
                        state_r <= IDLE;
                        fault_r <= 1'b1;
                        cause_r <= 2'b11;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    req_r   <= 1'b0;
                end
            endcase
        end
    end

    assign Ready_o          = (state_r == IDLE);
    assign dmem.DmemReq_o   = req_r;
    assign dmem.DmemWe_o    = we_r;
    assign dmem.DmemAddr_o  = addr_r;
    assign dmem.DmemBe_o    = be_r;
    assign dmem.DmemWdata_o = wdata_r;
    assign LoadValid_o      = load_valid_r;
    assign LoadData_o       = load_data_r;
    assign StoreDone_o      = store_done_r;
    assign Fault_o          = fault_r;
    assign FaultCause_o     = cause_r;

endmodule

// File: tb/tb_load_store_unit.sv
// -----------------------------------------------------------------------------
// tb_load_store_unit
// Directed bench for load_store_unit (TIMEOUT_CYCLES=4). Inputs change 1ns
// after a rising edge; outputs are checked at that same point.
// -----------------------------------------------------------------------------
module tb_load_store_unit;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid, mem_read, mem_write;
    logic [2:0]  funct3;
    logic [31:0] addr, store_data;
    logic        ready, load_valid, store_done, fault;
    logic [31:0] load_data;
    logic [1:0]  fault_cause;
    int          n_checks = 0;
    int          n_fails  = 0;

    load_store_unit_if bus ();

    load_store_unit #(.TIMEOUT_CYCLES(4)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .Valid_i      (valid),
        .MemRead_i    (mem_read),
        .MemWrite_i   (mem_write),
        .Funct3_i     (funct3),
        .Addr_i       (addr),
        .StoreData_i  (store_data),
        .Ready_o      (ready),
        .dmem         (bus.master),
        .LoadValid_o  (load_valid),
        .LoadData_o   (load_data),
        .StoreDone_o  (store_done),
        .Fault_o      (fault),
        .FaultCause_o (fault_cause)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic rd, input logic wr, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] d);
        valid = 1'b1; mem_read = rd; mem_write = wr; funct3 = f3; addr = a; store_data = d;
        cyc();
        valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
    endtask

    // Load with grant in the first request cycle and rvalid in the next.
    task automatic load_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] rdata, input logic [31:0] exp);
        bus.DmemGnt_i = 1'b1;
        issue(1'b1, 1'b0, f3, a, 32'd0);
        chk({tag, "_req"}, 32'(bus.DmemReq_o), 32'd1);
        chk({tag, "_we"}, 32'(bus.DmemWe_o), 32'd0);
        chk({tag, "_addr"}, bus.DmemAddr_o, {a[31:2], 2'b00});
        chk({tag, "_be"}, 32'(bus.DmemBe_o), 32'hF);
        cyc();
        bus.DmemGnt_i = 1'b0;
        chk({tag, "_req_drop"}, 32'(bus.DmemReq_o), 32'd0);
        chk({tag, "_busy"}, 32'(ready), 32'd0);
        bus.DmemRvalid_i = 1'b1; bus.DmemRdata_i = rdata;
        cyc();
        bus.DmemRvalid_i = 1'b0;
        chk({tag, "_lv"}, 32'(load_valid), 32'd1);
        chk({tag, "_data"}, load_data, exp);
        chk({tag, "_ready"}, 32'(ready), 32'd1);
        cyc();
        chk({tag, "_lv_pulse"}, 32'(load_valid), 32'd0);
        chk({tag, "_data_hold"}, load_data, exp);
    endtask

    // Store granted in the first request cycle.
    task automatic store_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                            input logic [31:0] d, input logic [3:0] be, input logic [31:0] wd);
        bus.DmemGnt_i = 1'b1;
        issue(1'b0, 1'b1, f3, a, d);
        chk({tag, "_req"}, 32'(bus.DmemReq_o), 32'd1);
        chk({tag, "_we"}, 32'(bus.DmemWe_o), 32'd1);
        chk({tag, "_addr"}, bus.DmemAddr_o, {a[31:2], 2'b00});
        chk({tag, "_be"}, 32'(bus.DmemBe_o), 32'(be));
        chk({tag, "_wdata"}, bus.DmemWdata_o, wd);
        chk({tag, "_done_early"}, 32'(store_done), 32'd0);
        cyc();
        bus.DmemGnt_i = 1'b0;
        chk({tag, "_done"}, 32'(store_done), 32'd1);
        chk({tag, "_req_drop"}, 32'(bus.DmemReq_o), 32'd0);
        chk({tag, "_ready"}, 32'(ready), 32'd1);
        cyc();
        chk({tag, "_done_pulse"}, 32'(store_done), 32'd0);
    endtask

    // Op rejected before reaching the bus.
    task automatic fault_op(input string tag, input logic rd, input logic wr, input logic [2:0] f3,
                            input logic [31:0] a, input logic [1:0] cause);
        issue(rd, wr, f3, a, 32'h0);
        chk({tag, "_fault"}, 32'(fault), 32'd1);
        chk({tag, "_cause"}, 32'(fault_cause), 32'(cause));
        chk({tag, "_noreq"}, 32'(bus.DmemReq_o), 32'd0);
        chk({tag, "_ready"}, 32'(ready), 32'd1);
        cyc();
        chk({tag, "_fault_pulse"}, 32'(fault), 32'd0);
        chk({tag, "_noreq2"}, 32'(bus.DmemReq_o), 32'd0);
        chk({tag, "_cause_hold"}, 32'(fault_cause), 32'(cause));
    endtask

    initial begin
        rst_n = 1'b0; valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
        funct3 = 3'd0; addr = 32'd0; store_data = 32'd0;
        bus.DmemGnt_i = 1'b0; bus.DmemRvalid_i = 1'b0; bus.DmemRdata_i = 32'd0;
        cyc(); cyc();
        chk("rst_ready", 32'(ready), 32'd1);
        chk("rst_req", 32'(bus.DmemReq_o), 32'd0);
        chk("rst_lv", 32'(load_valid), 32'd0);
        chk("rst_data", load_data, 32'd0);
        chk("rst_fault", 32'(fault), 32'd0);
        chk("rst_cause", 32'(fault_cause), 32'd0);
        rst_n = 1'b1;
        cyc();

        // Stores: lane replication and byte enables.
        store_op("sb", 3'b000, 32'h0000_1003, 32'h0000_00AB, 4'b1000, 32'hABAB_ABAB);
        store_op("sb1", 3'b000, 32'h0000_1001, 32'h1234_5677, 4'b0010, 32'h7777_7777);
        store_op("sh", 3'b001, 32'h0000_1002, 32'hFFFF_BEEF, 4'b1100, 32'hBEEF_BEEF);
        store_op("sw", 3'b010, 32'h0000_1004, 32'hCAFE_F00D, 4'b1111, 32'hCAFE_F00D);

        // Loads: extraction and extension.
        load_op("lb", 3'b000, 32'h0000_2002, 32'h0080_0000, 32'hFFFF_FF80);
        load_op("lbu", 3'b100, 32'h0000_2002, 32'h0080_0000, 32'h0000_0080);
        load_op("lw", 3'b010, 32'h0000_2000, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
        load_op("lh", 3'b001, 32'h0000_2002, 32'h8001_0000, 32'hFFFF_8001);
        load_op("lhu", 3'b101, 32'h0000_2002, 32'h8001_0000, 32'h0000_8001);
        load_op("lb3", 3'b000, 32'h0000_2003, 32'h7F00_0000, 32'h0000_007F);

        // Faults.
        fault_op("lh_mis", 1'b1, 1'b0, 3'b001, 32'h0000_3001, 2'b01);
        fault_op("sw_mis", 1'b0, 1'b1, 3'b010, 32'h0000_3002, 2'b01);
        fault_op("sw_ill", 1'b0, 1'b1, 3'b011, 32'h0000_4000, 2'b10);
        fault_op("ld_ill", 1'b1, 1'b0, 3'b110, 32'h0000_4001, 2'b10);
        fault_op("rw_ill", 1'b1, 1'b1, 3'b000, 32'h0000_4000, 2'b10);

        // Valid with no op: ignored.
        issue(1'b0, 1'b0, 3'b010, 32'h0000_4000, 32'h0);
        chk("nop_fault", 32'(fault), 32'd0);
        chk("nop_req", 32'(bus.DmemReq_o), 32'd0);
        chk("nop_ready", 32'(ready), 32'd1);

        // Grant withheld 3 cycles: 4 stable request cycles, grant on the last.
        bus.DmemGnt_i = 1'b0;
        issue(1'b0, 1'b1, 3'b001, 32'h0000_5002, 32'h1234_CDEF);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("hold_req%0d", i), 32'(bus.DmemReq_o), 32'd1);
            chk($sformatf("hold_addr%0d", i), bus.DmemAddr_o, 32'h0000_5000);
            chk($sformatf("hold_be%0d", i), 32'(bus.DmemBe_o), 32'hC);
            chk($sformatf("hold_wd%0d", i), bus.DmemWdata_o, 32'hCDEF_CDEF);
            chk($sformatf("hold_ready%0d", i), 32'(ready), 32'd0);
            chk($sformatf("hold_done%0d", i), 32'(store_done), 32'd0);
            chk($sformatf("hold_fault%0d", i), 32'(fault), 32'd0);
            if (i == 3) bus.DmemGnt_i = 1'b1;
            cyc();
        end
        bus.DmemGnt_i = 1'b0;
        chk("hold_done", 32'(store_done), 32'd1);
        chk("hold_nofault", 32'(fault), 32'd0);
        cyc();
        chk("hold_done_once", 32'(store_done), 32'd0);

        // Load timeout: grant, then 3 WAIT cycles without rvalid.
        bus.DmemGnt_i = 1'b1;
        issue(1'b1, 1'b0, 3'b010, 32'h0000_6000, 32'h0);
        cyc();
        bus.DmemGnt_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("to_wait_fault%0d", i), 32'(fault), 32'd0);
            chk($sformatf("to_wait_ready%0d", i), 32'(ready), 32'd0);
            cyc();
        end
        chk("to_fault", 32'(fault), 32'd1);
        chk("to_cause", 32'(fault_cause), 32'd3);
        chk("to_ready", 32'(ready), 32'd1);
        chk("to_lv", 32'(load_valid), 32'd0);
        bus.DmemRvalid_i = 1'b1; bus.DmemRdata_i = 32'h5555_5555;
        cyc();
        bus.DmemRvalid_i = 1'b0;
        chk("stray_lv", 32'(load_valid), 32'd0);
        chk("stray_fault", 32'(fault), 32'd0);
        chk("stray_data", load_data, 32'h0000_007F);

        // Reset while the request is pending: request drops without an edge.
        bus.DmemGnt_i = 1'b0;
        issue(1'b1, 1'b0, 3'b010, 32'h0000_7000, 32'h0);
        chk("rreq_req", 32'(bus.DmemReq_o), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("rreq_req_drop", 32'(bus.DmemReq_o), 32'd0);
        chk("rreq_ready", 32'(ready), 32'd1);
        cyc();
        rst_n = 1'b1;
        cyc();

        // Reset in WAIT.
        bus.DmemGnt_i = 1'b1;
        issue(1'b1, 1'b0, 3'b010, 32'h0000_7000, 32'h0);
        cyc();
        bus.DmemGnt_i = 1'b0;
        chk("rwait_busy", 32'(ready), 32'd0);
        #2 rst_n = 1'b0;
        #1;
        chk("rwait_req", 32'(bus.DmemReq_o), 32'd0);
        chk("rwait_lv", 32'(load_valid), 32'd0);
        chk("rwait_ready", 32'(ready), 32'd1);
        cyc();
        rst_n = 1'b1;
        cyc();
        load_op("post_rst_lw", 3'b010, 32'h0000_7004, 32'h1122_3344, 32'h1122_3344);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
